// File: rtl/product_accumulator_if.sv
// Handshake bundle between the multiplier, the accumulator and the result consumer.
// Carries the run request, the product stream (valid/ready) and the result (valid/ready).
// master = stimulus/upstream side, slave = product_accumulator.
interface product_accumulator_if #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int LEN_W  = 5
);
  logic              start;      // run request, honoured only in IDLE
  logic [LEN_W-1:0]  len;        // products in the run, latched with start
  logic              prod_valid; // upstream product valid
  logic [PROD_W-1:0] prod;       // unsigned product
  logic              prod_ready; // accumulator takes a product this cycle
  logic              acc_valid;  // result available
  logic [ACC_W-1:0]  acc_out;    // accumulated sum
  logic              acc_ready;  // downstream takes the result
  logic              overflow;   // sticky carry-out of the run
  logic              busy;       // run in progress or result pending

  modport master (
    output start, len, prod_valid, prod, acc_ready,
    input  prod_ready, acc_valid, acc_out, overflow, busy
  );

  modport slave (
    input  start, len, prod_valid, prod, acc_ready,
    output prod_ready, acc_valid, acc_out, overflow, busy
  );
endinterface

// File: rtl/product_accumulator.sv
// Sums a programmed number of unsigned products into a wide accumulator.
// Latency: prod_ready the cycle after start; acc_valid the cycle after the last beat (or after start when len=0).
// Backpressure: one product per cycle in ACCUM; result held stable in DONE until acc_ready.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries start/len, the
// prod_valid/prod/prod_ready stream, and the acc_valid/acc_out/acc_ready result plus overflow/busy.
module product_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int LEN_W  = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  product_accumulator_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [LEN_W-1:0] rem_q, rem_d;

  logic [PROD_W-1:0] prod_in;
  logic [ACC_W:0]    sum;   // one extra bit captures the carry-out
  logic              beat;

  assign prod_in = bus.prod;
  // prod_ready is exactly "state is ACCUM", so a beat needs only the valid.
  assign beat    = (state_q == ACCUM) && bus.prod_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = (bus.len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (beat && (rem_q == LEN_W'(1))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.acc_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: acc/overflow are cleared only by an accepted start, so the
  // last result stays visible in IDLE.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    rem_d = rem_q;
    sum   = {1'b0, acc_q} + (ACC_W+1)'(prod_in);
    if ((state_q == IDLE) && bus.start) begin
      acc_d = '0;
      ovf_d = 1'b0;
      rem_d = bus.len;
    end else if (beat) begin
      acc_d = sum[ACC_W-1:0];
      ovf_d = ovf_q | sum[ACC_W];
      rem_d = rem_q - LEN_W'(1);
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    bus.prod_ready = 1'b0;
    bus.acc_valid  = 1'b0;
    bus.busy       = 1'b0;
    case (state_q)
      ACCUM: begin
        bus.prod_ready = 1'b1;
        bus.busy       = 1'b1;
      end
      DONE: begin
        bus.acc_valid = 1'b1;
        bus.busy      = 1'b1;
      end
      default: ;
    endcase
    bus.acc_out  = acc_q;
    bus.overflow = ovf_q;
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Drives two accumulators (ACC_W=16 and ACC_W=10) with identical stimulus and
// compares each against a plain-arithmetic model of the run's total.
module tb_product_accumulator;

  logic clk;
  logic rst_n;
  logic       start;
  logic [4:0] len;
  logic       prod_valid;
  logic [7:0] prod;
  logic       acc_ready;

  int checks = 0;
  int errors = 0;
  int prods[$];

  product_accumulator_if #(.PROD_W(8), .ACC_W(16), .LEN_W(5)) bus16 ();
  product_accumulator_if #(.PROD_W(8), .ACC_W(10), .LEN_W(5)) bus10 ();

  assign bus16.start = start;      assign bus10.start = start;
  assign bus16.len = len;          assign bus10.len = len;
  assign bus16.prod_valid = prod_valid; assign bus10.prod_valid = prod_valid;
  assign bus16.prod = prod;        assign bus10.prod = prod;
  assign bus16.acc_ready = acc_ready;   assign bus10.acc_ready = acc_ready;

  product_accumulator #(.PROD_W(8), .ACC_W(16), .LEN_W(5)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16)
  );
  product_accumulator #(.PROD_W(8), .ACC_W(10), .LEN_W(5)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .bus(bus10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model: the result is the plain sum truncated to the accumulator width;
  // overflow means the sum ever passed the width's maximum.
  task automatic chk_result(input string tag, input int total);
    chk({tag, "_acc16"}, bus16.acc_out, total % 65536);
    chk({tag, "_ovf16"}, bus16.overflow, (total > 65535) ? 1 : 0);
    chk({tag, "_acc10"}, bus10.acc_out, total % 1024);
    chk({tag, "_ovf10"}, bus10.overflow, (total > 1023) ? 1 : 0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, bus16.busy, 0);
    chk({tag, "_prdy"}, bus16.prod_ready, 0);
    chk({tag, "_avld"}, bus16.acc_valid, 0);
    chk({tag, "_avld10"}, bus10.acc_valid, 0);
  endtask

  // Runs one transaction using prods[0..L-1]. Called and returns at a negedge in IDLE.
  task automatic do_run(input string tag, input int L, input int bp,
                        input bit gaps, input bit noise);
    int total;
    total = 0;
    chk_idle({tag, "_pre"});
    start = 1'b1;
    len   = 5'(L);
    @(negedge clk);
    start = 1'b0;
    len   = noise ? 5'($urandom) : 5'(L);
    if (L == 0) begin
      chk({tag, "_len0_avld"}, bus16.acc_valid, 1);
      chk({tag, "_len0_prdy"}, bus16.prod_ready, 0);
    end else begin
      chk({tag, "_prdy_first"}, bus16.prod_ready, 1);
      chk({tag, "_busy_accum"}, bus16.busy, 1);
      for (int i = 0; i < L; i++) begin
        if (gaps) begin
          int g;
          g = $urandom_range(0, 2);
          repeat (g) begin
            prod_valid = 1'b0;
            prod = 8'($urandom);
            if (noise) start = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk({tag, "_gap_prdy"}, bus16.prod_ready, 1);
            chk({tag, "_gap_avld"}, bus16.acc_valid, 0);
          end
        end
        prod_valid = 1'b1;
        prod  = 8'(prods[i]);
        total += prods[i];
        if (noise) start = 1'($urandom_range(0, 1));
        @(negedge clk);
        prod_valid = 1'b0;
        start = 1'b0;
        if (i < L - 1) begin
          chk({tag, "_mid_prdy"}, bus16.prod_ready, 1);
          chk({tag, "_mid_avld"}, bus16.acc_valid, 0);
        end
      end
      chk({tag, "_done_avld"}, bus16.acc_valid, 1);
      chk({tag, "_done_avld10"}, bus10.acc_valid, 1);
      chk({tag, "_done_prdy"}, bus16.prod_ready, 0);
    end
    chk_result({tag, "_res"}, total);
    repeat (bp) begin
      acc_ready = 1'b0;
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        len = 5'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_bp_avld"}, bus16.acc_valid, 1);
      chk({tag, "_bp_acc"}, bus16.acc_out, total % 65536);
    end
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
    chk_idle({tag, "_post"});
    chk_result({tag, "_held"}, total);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    len = '0;
    prod_valid = 1'b0;
    prod = '0;
    acc_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    chk_result("reset", 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 10+20+30+40 back to back, a couple of backpressure cycles
    prods = '{10, 20, 30, 40};
    do_run("basic", 4, 2, 1'b0, 1'b0);

    // 225 x3 with gaps and ignored start/len noise
    prods = '{225, 225, 225};
    do_run("gaps", 3, 0, 1'b1, 1'b1);

    // 225 x5: wraps the 10-bit accumulator (101, overflow)
    prods = '{225, 225, 225, 225, 225};
    do_run("wrap", 5, 0, 1'b0, 1'b0);
    // overflow must clear on the next run
    prods = '{5};
    do_run("clear", 1, 0, 1'b0, 1'b0);

    // len=0 with noise pulses in DONE
    prods = {};
    do_run("len0", 0, 3, 1'b0, 1'b1);

    // result 100 held under 8 cycles of backpressure
    prods = '{10, 20, 30, 40};
    do_run("bp", 4, 8, 1'b0, 1'b1);

    // Reset after 2 of 4 beats
    start = 1'b1;
    len = 5'd4;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      prod_valid = 1'b1;
      prod = 8'd50;
      @(negedge clk);
    end
    prod_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_acc", bus16.acc_out, 0);
    chk("rst_mid_prdy", bus16.prod_ready, 0);
    chk("rst_mid_busy", bus16.busy, 0);
    chk("rst_mid_avld", bus16.acc_valid, 0);
    chk("rst_mid_ovf", bus16.overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("after_rst");
    prods = '{1, 2};
    do_run("post_rst", 2, 0, 1'b0, 1'b0);

    // Randomized runs
    for (int r = 0; r < 20; r++) begin
      int L;
      L = $urandom_range(0, 31);
      prods = {};
      for (int k = 0; k < L; k++) prods.push_back($urandom_range(0, 225));
      do_run("rand", L, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential accumulation stage that sits directly downstream of the 4x4 array multiplier. It consumes a stream of 8-bit products over a valid/ready handshake. It sums a programmed number of them into a wide accumulator and presents the result on a second valid/ready handshake. Together with the multiplier it forms the team's multiply-accumulate datapath for dot-product style workloads.

## Interface
- PROD_W, 8, product width; matches the multiplier output P.
- ACC_W, 16, accumulator and result width; must be >= PROD_W.
- LEN_W, 5, width of the run-length field; maximum run is 2^LEN_W - 1 products.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  run request; sampled only in IDLE.
- len  input  LEN_W  number of products in the run; latched on an accepted start.
- prod_valid  input  1  upstream product valid.
- prod  input  PROD_W  unsigned product from the multiplier.
- prod_ready  output  1  block accepts a product this cycle.
- acc_valid  output  1  result available.
- acc_out  output  ACC_W  accumulated sum.
- acc_ready  input  1  downstream accepts the result.
- overflow  output  1  sticky flag: the run's sum exceeded 2^ACC_W - 1.
- busy  output  1  high in ACCUM or DONE.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - start=1 and len!=0: latch remaining=len, clear acc and overflow, go to ACCUM.
  - start=1 and len=0: clear acc and overflow, go straight to DONE (result 0).
  - start=0: stay in IDLE.
- ACCUM:
  - prod_ready=1.
  - A beat is accepted when prod_valid && prod_ready.
  - On each beat: acc <= (acc + prod) mod 2^ACC_W; overflow <= overflow | carry-out; remaining decrements.
  - The beat that brings remaining from 1 to 0 moves the FSM to DONE.
  - No beat: state, acc and remaining hold.
- DONE:
  - acc_valid=1; acc_out and overflow stable.
  - acc_valid && acc_ready moves the FSM to IDLE.
  - acc_out and overflow hold their values in IDLE until the next accepted start.
- start is ignored outside IDLE; len changes outside IDLE are ignored.
- prod is zero-extended to ACC_W before the add. Arithmetic is unsigned.

## Timing
- Reset values:
  - state=IDLE, acc_out=0, overflow=0, remaining=0.
  - prod_ready=0, acc_valid=0, busy=0.
- prod_ready, acc_valid and busy are decoded from the registered state only. They have no combinational path from any input.
- Latency:
  - start accepted at edge N: prod_ready=1 from cycle N+1.
  - Last beat accepted at edge M: acc_valid=1 from cycle M+1.
  - With len=0: acc_valid=1 in the cycle after start.
- Throughput: one product per cycle. A run of L products with prod_valid held high takes L cycles in ACCUM.
- The earliest next start is the cycle after acc_valid && acc_ready (IDLE must be visited for one cycle minimum).
- acc_valid stays high indefinitely under acc_ready=0 backpressure; outputs must not change.
- Reset mid-run (rst_n low in any state):
  - All outputs return to their reset values immediately (asynchronous).
  - The partial sum is discarded.
  - The first cycle after rst_n deasserts is IDLE.

## Test plan
- Reset, then start with len=4; products 10, 20, 30, 40 back-to-back -> acc_valid one cycle after the 4th beat, acc_out=100, overflow=0, busy drops after acc_ready.
- len=3 with prod_valid toggling (gaps of 2 cycles); products 225, 225, 225 -> acc_out=675; acc, state and remaining hold during gaps; prod_ready stays 1 throughout ACCUM.
- ACC_W=10 override, len=5, each product 225 -> acc_out=1125 mod 1024=101, overflow=1. The next run with len=1 and product 5 -> acc_out=5, overflow=0.
- len=0 start -> acc_valid next cycle, acc_out=0, prod_ready never asserts. Also: start pulsed during ACCUM and DONE -> ignored, and len is not re-latched.
- Backpressure: result 100 pending, acc_ready=0 for 8 cycles -> acc_valid and acc_out=100 held. acc_ready=1 -> IDLE next cycle, acc_valid=0.
- Reset asserted after 2 of 4 beats -> all outputs 0 the same cycle. After deassert, a new run with len=2 and products 1, 2 -> acc_out=3.
